// File: rtl/advtim_brk_pkg.sv
// ----------------------------------------------------------------------------
// advtim_brk_pkg
// Shared constants for the advanced-timer break response block.
//   ST_IDLE/ST_RUN/ST_BREAK/ST_HOLD : 2-bit FSM state encoding (also the
//                                     readback value on state_o)
//   BRK_CNT_W                       : width of the optional break-event
//                                     counter (BRK_EVENT_CNT_EN builds only)
// ----------------------------------------------------------------------------
package advtim_brk_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_BREAK = 2'd2;
   localparam logic [1:0] ST_HOLD  = 2'd3;

   localparam int BRK_CNT_W = 8;

endpackage : advtim_brk_pkg

// File: rtl/brk_output_force.sv
// ----------------------------------------------------------------------------
// brk_output_force
// Purely combinational per-channel pin selection. PWM passes through only
// while the FSM is in RUN and no fault is present; otherwise every channel
// is driven to its programmed idle level.
// Ports:
//   state_i  : current FSM state
//   fault_i  : fault indication (forces idle in the same cycle)
//   pwm_i    : main PWM from the generator        [W]
//   pwmn_i   : complementary PWM from the generator [W]
//   ois_i    : idle level for main outputs         [W]
//   oisn_i   : idle level for complementary outputs [W]
//   pwm_o    : main outputs to pins               [W]
//   pwmn_o   : complementary outputs to pins      [W]
// ----------------------------------------------------------------------------
module brk_output_force
   import advtim_brk_pkg::*;
#(
   parameter int W = 4
) (
   input  logic [1:0]   state_i,
   input  logic         fault_i,
   input  logic [W-1:0] pwm_i,
   input  logic [W-1:0] pwmn_i,
   input  logic [W-1:0] ois_i,
   input  logic [W-1:0] oisn_i,
   output logic [W-1:0] pwm_o,
   output logic [W-1:0] pwmn_o
);

   logic pass;

   // The fault term bypasses the state register so pins go idle with zero
   // latency, before the FSM has even seen the fault.
   assign pass   = (state_i == ST_RUN) && !fault_i;
   assign pwm_o  = pass ? pwm_i  : ois_i;
   assign pwmn_o = pass ? pwmn_i : oisn_i;

endmodule : brk_output_force

// File: rtl/break_response_ctrl.sv
// ----------------------------------------------------------------------------
// break_response_ctrl
// Main-output-enable (MOE) sequencer with break handling. Owns the MOE FSM
// (IDLE/RUN/BREAK/HOLD), software set/clear, automatic re-arm on update event
// (AOE), the sticky break flag and the break interrupt pulse.
// Optional feature macro: BRK_EVENT_CNT_EN adds brk_cnt, a saturating count
// of break entries cleared by r_bif_clr.
// Ports:
//   pe_gen_clk, pe_gen_rst : clock, synchronous active-high reset
//   fault_detected         : registered fault from fault detection
//   update_event           : 1-cycle counter update pulse
//   r_moe_set / r_moe_clr  : 1-cycle software MOE writes
//   r_aoe                  : enable automatic re-arm on update_event
//   r_bif_clr              : 1-cycle break flag clear
//   r_ois / r_oisn         : idle levels [NCH]
//   pwm_in / pwmn_in       : PWM from generator [NCH]
//   pwm_out / pwmn_out     : to pins [NCH]
//   moe, bif, int_status_brk, state_o : status
//   brk_cnt                : break entry count (BRK_EVENT_CNT_EN only)
// ----------------------------------------------------------------------------
module break_response_ctrl
   import advtim_brk_pkg::*;
#(
   parameter int NCH = 4
) (
   input  logic                 pe_gen_clk,
   input  logic                 pe_gen_rst,
   input  logic                 fault_detected,
   input  logic                 update_event,
   input  logic                 r_moe_set,
   input  logic                 r_moe_clr,
   input  logic                 r_aoe,
   input  logic                 r_bif_clr,
   input  logic [NCH-1:0]       r_ois,
   input  logic [NCH-1:0]       r_oisn,
   input  logic [NCH-1:0]       pwm_in,
   input  logic [NCH-1:0]       pwmn_in,
   output logic [NCH-1:0]       pwm_out,
   output logic [NCH-1:0]       pwmn_out,
   output logic                 moe,
   output logic                 bif,
   output logic                 int_status_brk,
`ifdef BRK_EVENT_CNT_EN
   output logic [BRK_CNT_W-1:0] brk_cnt,
`endif
   output logic [1:0]           state_o
);

   logic [1:0] state_q, state_d;
   logic       bif_q, bif_d;
   logic       int_q;
   logic       brk_entry;

   // A break is entered only from states where the outputs were (or are
   // about to be) live; BREAK itself just waits for the fault to clear.
   assign brk_entry = fault_detected && ((state_q == ST_RUN) || (state_q == ST_HOLD));

   // NOTE: every combinational output gets a default before the case so no
   // path leaves it unassigned, which would infer a latch.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (r_moe_set && !fault_detected) state_d = ST_RUN;
         ST_RUN: begin
            if (fault_detected)  state_d = ST_BREAK;
            else if (r_moe_clr)  state_d = ST_IDLE;
         end
         ST_BREAK: if (!fault_detected) state_d = ST_HOLD;
         ST_HOLD: begin
            if (fault_detected)                          state_d = ST_BREAK;
            else if (r_moe_clr)                          state_d = ST_IDLE;
            else if (r_moe_set || (update_event && r_aoe)) state_d = ST_RUN;
         end
         default:  state_d = ST_IDLE;
      endcase
   end

   // Break entry wins over a same-cycle software clear.
   assign bif_d = brk_entry ? 1'b1 : (r_bif_clr ? 1'b0 : bif_q);

   // NOTE: state is updated with non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge pe_gen_clk) begin
      if (pe_gen_rst) begin
         state_q <= ST_IDLE;
         bif_q   <= 1'b0;
         int_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         bif_q   <= bif_d;
         int_q   <= brk_entry;
      end
   end

`ifdef BRK_EVENT_CNT_EN
   logic [BRK_CNT_W-1:0] brk_cnt_q;

   // Increment (or hold at saturation) takes precedence over the clear.
   always_ff @(posedge pe_gen_clk) begin
      if (pe_gen_rst) begin
         brk_cnt_q <= '0;
      end else if (brk_entry) begin
         if (brk_cnt_q != '1) brk_cnt_q <= brk_cnt_q + BRK_CNT_W'(1);
      end else if (r_bif_clr) begin
         brk_cnt_q <= '0;
      end
   end

   assign brk_cnt = brk_cnt_q;
`endif

   brk_output_force #(
      .W(NCH)
   ) u_force (
      .state_i (state_q),
      .fault_i (fault_detected),
      .pwm_i   (pwm_in),
      .pwmn_i  (pwmn_in),
      .ois_i   (r_ois),
      .oisn_i  (r_oisn),
      .pwm_o   (pwm_out),
      .pwmn_o  (pwmn_out)
   );

   assign moe            = (state_q == ST_RUN);
   assign bif            = bif_q;
   assign int_status_brk = int_q;
   assign state_o        = state_q;

endmodule : break_response_ctrl
